// File: rtl/lsu_mem_ctrl.sv
// Load/store unit between MEM stage and data_mem: B/H/W loads with extension, sub-word stores via RMW.
// Latency: load/word/MMIO store 2 cycles, sub-word RAM store 3, error 1 (acceptance edge to resp_valid).
// Backpressure: req_ready high only in IDLE. Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
module lsu_mem_ctrl #(
    parameter logic [15:0] MMIO_HI = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        memread,
    output logic        memwrite,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_STORE, S_RMW_RD, S_RMW_WR, S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    logic        memread_q, memread_d;
    logic        memwrite_q, memwrite_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_writedata_q, mem_writedata_d;

    logic        req_illegal;
    logic        req_err;
    logic        req_mmio;
    logic [31:0] eff_addr;
    logic [31:0] aligned_addr;
    logic [31:0] mmio_wdata;
    logic [4:0]  lane_shamt;
    logic [31:0] rd_shifted;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_ext;
    logic [31:0] lane_mask;
    logic [31:0] lane_data;
    logic [31:0] merged;

    // Request decode: legality, alignment handling and region.
    always_comb begin
        req_illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                      (req_funct3 == 3'b111) || (req_we && req_funct3[2]);
`ifdef LSU_MISALIGN_TRAP_EN
        eff_addr = req_addr;
        req_err  = req_illegal ||
                   ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
        req_err = req_illegal;
        case (req_funct3[1:0])
            2'b01:   eff_addr = {req_addr[31:1], 1'b0};
            2'b10:   eff_addr = {req_addr[31:2], 2'b00};
            default: eff_addr = req_addr;
        endcase
`endif
        aligned_addr = {eff_addr[31:2], 2'b00};
        req_mmio     = (eff_addr[31:16] == MMIO_HI);
        case (req_funct3[1:0])
            2'b00:   mmio_wdata = {24'b0, req_wdata[7:0]};
            2'b01:   mmio_wdata = {16'b0, req_wdata[15:0]};
            default: mmio_wdata = req_wdata;
        endcase
    end

    // Lane extraction for loads and lane merge for read-modify-write.
    always_comb begin
        lane_shamt = {addr_q[1:0], 3'b000};
        rd_shifted = mem_readdata >> lane_shamt;
        ld_byte    = rd_shifted[7:0];
        ld_half    = addr_q[1] ? mem_readdata[31:16] : mem_readdata[15:0];
        case (funct3_q[1:0])
            2'b00:   load_ext = {{24{~funct3_q[2] & ld_byte[7]}}, ld_byte};
            2'b01:   load_ext = {{16{~funct3_q[2] & ld_half[15]}}, ld_half};
            default: load_ext = mem_readdata;
        endcase
        if (funct3_q[1:0] == 2'b01) begin
            lane_mask = 32'h0000_FFFF << {addr_q[1], 4'b0000};
            lane_data = {16'b0, wdata_q[15:0]} << {addr_q[1], 4'b0000};
        end else begin
            lane_mask = 32'h0000_00FF << lane_shamt;
            lane_data = {24'b0, wdata_q[7:0]} << lane_shamt;
        end
        merged = (mem_readdata & ~lane_mask) | lane_data;
    end

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        funct3_d        = funct3_q;
        req_ready_d     = 1'b0;
        resp_valid_d    = 1'b0;
        resp_rdata_d    = 32'b0;
        resp_err_d      = 1'b0;
        memread_d       = 1'b0;
        memwrite_d      = 1'b0;
        mem_addr_d      = mem_addr_q;
        mem_writedata_d = mem_writedata_q;
        case (state_q)
            S_IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    addr_d      = eff_addr;
                    wdata_d     = req_wdata;
                    funct3_d    = req_funct3;
                    req_ready_d = 1'b0;
                    if (req_err) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (!req_we) begin
                        state_d    = S_LOAD;
                        memread_d  = 1'b1;
                        mem_addr_d = aligned_addr;
                    end else if (req_mmio || (req_funct3[1:0] == 2'b10)) begin
                        // MMIO stores go out unshifted with the full address; no RMW.
                        state_d         = S_STORE;
                        memwrite_d      = 1'b1;
                        mem_addr_d      = req_mmio ? eff_addr : aligned_addr;
                        mem_writedata_d = req_mmio ? mmio_wdata : req_wdata;
                    end else begin
                        state_d    = S_RMW_RD;
                        memread_d  = 1'b1;
                        mem_addr_d = aligned_addr;
                    end
                end
            end
            S_LOAD: begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = load_ext;
            end
            S_STORE: begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
            end
            S_RMW_RD: begin
                state_d         = S_RMW_WR;
                memwrite_d      = 1'b1;
                mem_writedata_d = merged;
            end
            S_RMW_WR: begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
            end
            S_RESP: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            addr_q          <= 32'b0;
            wdata_q         <= 32'b0;
            funct3_q        <= 3'b0;
            req_ready_q     <= 1'b1;
            resp_valid_q    <= 1'b0;
            resp_rdata_q    <= 32'b0;
            resp_err_q      <= 1'b0;
            memread_q       <= 1'b0;
            memwrite_q      <= 1'b0;
            mem_addr_q      <= 32'b0;
            mem_writedata_q <= 32'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            funct3_q        <= funct3_d;
            req_ready_q     <= req_ready_d;
            resp_valid_q    <= resp_valid_d;
            resp_rdata_q    <= resp_rdata_d;
            resp_err_q      <= resp_err_d;
            memread_q       <= memread_d;
            memwrite_q      <= memwrite_d;
            mem_addr_q      <= mem_addr_d;
            mem_writedata_q <= mem_writedata_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign resp_valid    = resp_valid_q;
    assign resp_rdata    = resp_rdata_q;
    assign resp_err      = resp_err_q;
    assign memread       = memread_q;
    assign memwrite      = memwrite_q;
    assign mem_addr      = mem_addr_q;
    assign mem_writedata = mem_writedata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a small word-write data_mem model and an MMIO sink.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        memread;
    logic        memwrite;
    logic [31:0] mem_addr;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;

    logic [31:0] ram [0:15];
    logic [31:0] mmio_addr;
    logic [31:0] mmio_data;
    int rd_cnt = 0, wr_cnt = 0, rv_cnt = 0, both_cnt = 0;
    int passed = 0, total = 0;
    int rd0, wr0, rv0;
    logic [31:0] exp_word;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.MMIO_HI(16'hFFFF)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .memread(memread), .memwrite(memwrite), .mem_addr(mem_addr),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata)
    );

    assign mem_readdata = ram[mem_addr[5:2]];

    always @(posedge clk) begin
        if (memwrite) begin
            if (mem_addr[31:16] == 16'hFFFF) begin
                mmio_addr <= mem_addr;
                mmio_data <= mem_writedata;
            end else begin
                ram[mem_addr[5:2]] <= mem_writedata;
            end
        end
    end

    always @(negedge clk) begin
        if (memread)              rd_cnt++;
        if (memwrite)             wr_cnt++;
        if (resp_valid)           rv_cnt++;
        if (memread && memwrite)  both_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = d;
        step();
        req_valid  = 1'b0;
        req_we     = ~we;
        req_funct3 = 3'b111;
        req_addr   = 32'hDEAD_BEEF;
        req_wdata  = 32'hCAFE_F00D;
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] exp);
        issue(1'b0, f3, a, 32'h0);
        chk({tag, " memread"}, memread, 1);
        chk({tag, " mem_addr"}, mem_addr, {a[31:2], 2'b00});
        chk({tag, " early resp"}, resp_valid, 0);
        step();
        chk({tag, " resp_valid"}, resp_valid, 1);
        chk({tag, " rdata"}, resp_rdata, exp);
        chk({tag, " err"}, resp_err, 0);
        step();
        chk({tag, " ready"}, req_ready, 1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = 32'h0;
        mmio_addr  = 32'h0;
        mmio_data  = 32'h0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        step();
        step();
        chk("rst req_ready", req_ready, 1);
        chk("rst resp_valid", resp_valid, 0);
        chk("rst resp_rdata", resp_rdata, 0);
        chk("rst resp_err", resp_err, 0);
        chk("rst memread", memread, 0);
        chk("rst memwrite", memwrite, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst mem_writedata", mem_writedata, 0);
        rst = 1'b0;

        // Word store
        issue(1'b1, 3'b010, 32'h10, 32'h80FF7F01);
        chk("sw memwrite", memwrite, 1);
        chk("sw memread", memread, 0);
        chk("sw mem_addr", mem_addr, 32'h10);
        chk("sw wdata", mem_writedata, 32'h80FF7F01);
        chk("sw ready low", req_ready, 0);
        step();
        chk("sw resp_valid", resp_valid, 1);
        chk("sw rdata", resp_rdata, 0);
        chk("sw memwrite off", memwrite, 0);
        step();
        chk("sw resp pulse", resp_valid, 0);
        chk("sw ram", ram[4], 32'h80FF7F01);

        do_load("lw", 3'b010, 32'h10, 32'h80FF7F01);
        do_load("lb", 3'b000, 32'h13, 32'hFFFFFF80);
        do_load("lbu", 3'b100, 32'h13, 32'h00000080);
        do_load("lh", 3'b001, 32'h12, 32'hFFFF80FF);
        do_load("lhu", 3'b101, 32'h12, 32'h000080FF);
        do_load("lb0", 3'b000, 32'h10, 32'h00000001);

        // Sub-word RAM store via read-modify-write
        issue(1'b1, 3'b000, 32'h11, 32'h000000AA);
        chk("sb rmw_rd memread", memread, 1);
        chk("sb rmw_rd memwrite", memwrite, 0);
        chk("sb rmw_rd addr", mem_addr, 32'h10);
        step();
        chk("sb rmw_wr memwrite", memwrite, 1);
        chk("sb rmw_wr memread", memread, 0);
        chk("sb rmw_wr addr", mem_addr, 32'h10);
        chk("sb rmw_wr data", mem_writedata, 32'h80FFAA01);
        chk("sb no early resp", resp_valid, 0);
        step();
        chk("sb resp_valid", resp_valid, 1);
        chk("sb resp_err", resp_err, 0);
        step();
        do_load("lw after sb", 3'b010, 32'h10, 32'h80FFAA01);

        // MMIO byte store: single write, masked, unshifted, no read
        rd0 = rd_cnt;
        issue(1'b1, 3'b000, 32'hFFFF0000, 32'h1234565A);
        chk("mmio memwrite", memwrite, 1);
        chk("mmio addr", mem_addr, 32'hFFFF0000);
        chk("mmio data", mem_writedata, 32'h0000005A);
        step();
        chk("mmio resp_valid", resp_valid, 1);
        chk("mmio single write", memwrite, 0);
        step();
        chk("mmio no memread", rd_cnt, rd0);
        chk("mmio sink", mmio_data, 32'h0000005A);
        chk("mmio ram untouched", ram[0], 32'h0);

        // Misaligned half store
        wr0 = wr_cnt;
        issue(1'b1, 3'b001, 32'h11, 32'h0000BEEF);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("sh mis resp_valid", resp_valid, 1);
        chk("sh mis resp_err", resp_err, 1);
        chk("sh mis rdata", resp_rdata, 0);
        chk("sh mis memwrite", memwrite, 0);
        step();
        chk("sh mis no write", wr_cnt, wr0);
        exp_word = 32'h80FFAA01;
`else
        chk("sh align memread", memread, 1);
        chk("sh align addr", mem_addr, 32'h10);
        step();
        chk("sh align data", mem_writedata, 32'h80FFBEEF);
        step();
        chk("sh align resp_valid", resp_valid, 1);
        chk("sh align resp_err", resp_err, 0);
        step();
        exp_word = 32'h80FFBEEF;
`endif
        chk("sh word", ram[4], exp_word);

        // Illegal funct3 on load, and unsigned size on store
        rd0 = rd_cnt;
        issue(1'b0, 3'b011, 32'h10, 32'h0);
        chk("ill ld resp_valid", resp_valid, 1);
        chk("ill ld resp_err", resp_err, 1);
        chk("ill ld memread", memread, 0);
        step();
        chk("ill ld err pulse", resp_err, 0);
        chk("ill ld ready", req_ready, 1);
        wr0 = wr_cnt;
        issue(1'b1, 3'b100, 32'h10, 32'h55);
        chk("ill sbu resp_err", resp_err, 1);
        step();
        chk("ill no access", rd_cnt + wr_cnt, rd0 + wr0);

        // Reset during RMW_RD aborts the store with no response
        issue(1'b1, 3'b000, 32'h10, 32'h00000077);
        chk("rst-rmw memread", memread, 1);
        wr0 = wr_cnt;
        rv0 = rv_cnt;
        rst = 1'b1;
        step();
        chk("rst-rmw memread off", memread, 0);
        chk("rst-rmw memwrite", memwrite, 0);
        chk("rst-rmw ready", req_ready, 1);
        chk("rst-rmw resp_valid", resp_valid, 0);
        rst = 1'b0;
        step();
        step();
        step();
        chk("rst-rmw no write", wr_cnt, wr0);
        chk("rst-rmw no resp", rv_cnt, rv0);
        chk("rst-rmw ram", ram[4], exp_word);
        do_load("lw after rst", 3'b010, 32'h10, exp_word);

        chk("never read+write", both_cnt, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
